alarm_responder: RTL and testbench
==================================

Name: alarm_responder

Overview:
- Downstream end of the alarm decision logic: consumes the combinational alarm output A as trigger input trig and drives the physical annunciators.
- Arm/disarm state machine, entry-delay countdown, timed siren burst with blinking lamp, and a saturating event counter.
- Turns the level-only alarm decision into a timed, user-acknowledgeable response.
- Sits between the alarm block and the board LEDs/buzzer.

Parameters:
- ENTRY_CYCLES, 8: clock cycles from trigger acceptance to siren start; legal range 1..256.
- SIREN_CYCLES, 32: length of one siren burst in cycles; legal range 1..256.
- BLINK_HALF, 4: lamp half-period in cycles while sounding; legal range 1..256.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- trig  input  1  alarm decision (A from alarm block); level, sampled synchronously.
- arm  input  1  arm request; level, sampled each edge.
- disarm  input  1  disarm request; level, sampled each edge; wins over every other input.
- siren  output  1  buzzer drive; high only in SOUND.
- lamp  output  1  blinking indicator; toggles in SOUND, 0 elsewhere.
- armed  output  1  1 in any state except IDLE.
- state  output  2  IDLE=0, ARMED=1, DELAY=2, SOUND=3.
- event_cnt  output  4  number of accepted triggers, saturating at 15.

Behaviour:
Reset and outputs:
- rst_n low asynchronously forces: state=IDLE, siren=0, lamp=0, armed=0, event_cnt=0, internal counters=0.
- This applies mid-DELAY and mid-SOUND as well.
- All outputs are registered, with no combinational path from inputs to outputs.

IDLE:
- arm=1 and disarm=0 -> ARMED.
- trig is ignored.

ARMED:
- disarm=1 -> IDLE.
- Else trig=1 -> DELAY, dcnt=ENTRY_CYCLES-1, event_cnt+1 (saturating).
- arm is ignored.

DELAY:
- disarm=1 -> IDLE.
- Else if dcnt==0 -> SOUND, dcnt=SIREN_CYCLES-1, lamp=1, bcnt=BLINK_HALF-1.
- Else dcnt-1.
- trig and arm are ignored.

SOUND:
- disarm=1 -> IDLE; siren and lamp low at that same edge.
- Else if dcnt==0:
  - trig=0 -> ARMED.
  - trig=1 -> retrigger: stay in SOUND, reload dcnt=SIREN_CYCLES-1, event_cnt+1 (saturating), lamp=1, bcnt=BLINK_HALF-1.
- Else dcnt-1.
- Blink counter: when bcnt==0, lamp toggles and bcnt reloads to BLINK_HALF-1; otherwise bcnt-1.

Outputs per state:
- siren = (state==SOUND).
- lamp = 0 outside SOUND.
- armed = (state!=IDLE).

Timing (E0 = edge where trig is sampled high in ARMED):
- DELAY holds for ENTRY_CYCLES cycles.
- siren rises at E0+ENTRY_CYCLES.
- siren falls at E0+ENTRY_CYCLES+SIREN_CYCLES if no retrigger.
- ENTRY_CYCLES=1 means siren rises one edge after DELAY entry.

Arithmetic:
- dcnt and bcnt are 8-bit unsigned.
- event_cnt holds at 15 with no wrap.

Simultaneous events:
- disarm beats trig, arm and counter expiry.
- arm and disarm together in IDLE: stay in IDLE.
- trig held high continuously in ARMED: only one event is counted per entry into DELAY.

Test Plan:
1. Reset/idle: rst_n=0 then 1; trig=1, arm=0 for 20 cycles -> state=0, siren=0, lamp=0, armed=0, event_cnt=0.
2. Full alarm: arm pulse -> state=1; trig high 1 cycle at E0 -> state=2, event_cnt=1; siren=1 at E0+8; lamp pattern 1111 0000 1111...; siren=0 and state=1 at E0+40.
3. Disarm priority: trig, then disarm=1 at E0+5 with trig=1 and arm=1 -> state=0 next edge, siren never asserts. Repeat with disarm at E0+20 (in SOUND) -> siren and lamp 0 at that edge.
4. Retrigger: trig held high through SOUND expiry -> siren stays high for 64 continuous cycles, event_cnt=2, lamp restarts at 1 at the reload edge.
5. Saturation: 17 alarm/expire cycles -> event_cnt=15, no wrap.
6. Async reset mid-SOUND: drop rst_n between clock edges at E0+12 -> all outputs 0 immediately, before the next edge; remains IDLE after release until arm.

Source files
------------

// File: rtl/alarm_responder.sv
// -----------------------------------------------------------------------------
// alarm_responder
//
// Turns the level-only alarm decision into a timed, acknowledgeable response:
// an arm/disarm state machine, an entry-delay countdown, a timed siren burst
// with a blinking lamp, and a saturating count of accepted triggers.
//
// Ports:
//   clk        in   1  system clock, rising edge active
//   rst_n      in   1  asynchronous active-low reset
//   trig       in   1  alarm decision level from the alarm block
//   arm        in   1  arm request (level)
//   disarm     in   1  disarm request (level), overrides everything else
//   siren      out  1  buzzer drive, high only while sounding
//   lamp       out  1  blinking indicator while sounding, 0 elsewhere
//   armed      out  1  high in every state except IDLE
//   state      out  2  IDLE=0, ARMED=1, DELAY=2, SOUND=3
//   event_cnt  out  4  accepted triggers, saturating at 15
// -----------------------------------------------------------------------------
module alarm_responder #(
    parameter int ENTRY_CYCLES = 8,
    parameter int SIREN_CYCLES = 32,
    parameter int BLINK_HALF   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trig,
    input  logic       arm,
    input  logic       disarm,
    output logic       siren,
    output logic       lamp,
    output logic       armed,
    output logic [1:0] state,
    output logic [3:0] event_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_DELAY = 2'd2,
        S_SOUND = 2'd3
    } state_t;

    // Counters load N-1 and expire on zero, so a phase lasts exactly N cycles.
    localparam logic [7:0] ENTRY_LD = 8'(ENTRY_CYCLES - 1);
    localparam logic [7:0] SIREN_LD = 8'(SIREN_CYCLES - 1);
    localparam logic [7:0] BLINK_LD = 8'(BLINK_HALF - 1);

    state_t     state_q, state_d;
    logic [7:0] dcnt_q, dcnt_d;
    logic [7:0] bcnt_q, bcnt_d;
    logic       lamp_q, lamp_d;
    logic [3:0] event_cnt_q, event_cnt_d;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction

    always_comb begin
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        bcnt_d      = bcnt_q;
        lamp_d      = 1'b0;
        event_cnt_d = event_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (arm && !disarm) begin
                    state_d = S_ARMED;
                end
            end

            S_ARMED: begin
                if (disarm) begin
                    state_d = S_IDLE;
                end else if (trig) begin
                    state_d     = S_DELAY;
                    dcnt_d      = ENTRY_LD;
                    event_cnt_d = sat_inc(event_cnt_q);
                end
            end

            S_DELAY: begin
                if (disarm) begin
                    state_d = S_IDLE;
                end else if (dcnt_q == 8'd0) begin
                    state_d = S_SOUND;
                    dcnt_d  = SIREN_LD;
                    lamp_d  = 1'b1;
                    bcnt_d  = BLINK_LD;
                end else begin
                    dcnt_d = dcnt_q - 8'd1;
                end
            end

            S_SOUND: begin
                if (disarm) begin
                    state_d = S_IDLE;
                end else if (dcnt_q == 8'd0) begin
                    if (trig) begin
                        // Retrigger restarts the burst and the blink phase.
                        dcnt_d      = SIREN_LD;
                        lamp_d      = 1'b1;
                        bcnt_d      = BLINK_LD;
                        event_cnt_d = sat_inc(event_cnt_q);
                    end else begin
                        state_d = S_ARMED;
                    end
                end else begin
                    dcnt_d = dcnt_q - 8'd1;
                    if (bcnt_q == 8'd0) begin
                        lamp_d = ~lamp_q;
                        bcnt_d = BLINK_LD;
                    end else begin
                        lamp_d = lamp_q;
                        bcnt_d = bcnt_q - 8'd1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            dcnt_q      <= 8'd0;
            bcnt_q      <= 8'd0;
            lamp_q      <= 1'b0;
            event_cnt_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            bcnt_q      <= bcnt_d;
            lamp_q      <= lamp_d;
            event_cnt_q <= event_cnt_d;
        end
    end

    // Pure decodes of flop state; no input reaches an output combinationally.
    assign siren     = (state_q == S_SOUND);
    assign armed     = (state_q != S_IDLE);
    assign state     = state_q;
    assign lamp      = lamp_q;
    assign event_cnt = event_cnt_q;

endmodule

// File: tb/tb_alarm_responder.sv
module tb_alarm_responder;

    logic       clk;
    logic       rst_n;
    logic       trig;
    logic       arm;
    logic       disarm;
    logic       siren;
    logic       lamp;
    logic       armed;
    logic [1:0] state;
    logic [3:0] event_cnt;

    int total;
    int bad;

    alarm_responder #(
        .ENTRY_CYCLES(8),
        .SIREN_CYCLES(32),
        .BLINK_HALF  (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .trig     (trig),
        .arm      (arm),
        .disarm   (disarm),
        .siren    (siren),
        .lamp     (lamp),
        .armed    (armed),
        .state    (state),
        .event_cnt(event_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".state"}, 32'(state), 0);
        chk({tag, ".siren"}, 32'(siren), 0);
        chk({tag, ".lamp"},  32'(lamp), 0);
        chk({tag, ".armed"}, 32'(armed), 0);
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step(1);
        arm = 1'b0;
    endtask

    initial begin
        int exp_evt;
        int exp_siren;
        int exp_lamp;
        total = 0;
        bad   = 0;
        rst_n  = 1'b0;
        trig   = 1'b1;
        arm    = 1'b0;
        disarm = 1'b0;

        // 1. Reset / idle: trig ignored while not armed
        step(2);
        chk_all_zero("rst");
        chk("rst.evt", 32'(event_cnt), 0);
        #2 rst_n = 1'b1;
        step(20);
        chk_all_zero("idle");
        chk("idle.evt", 32'(event_cnt), 0);
        trig = 1'b0;

        // arm together with disarm in IDLE stays IDLE
        arm = 1'b1; disarm = 1'b1;
        step(1);
        arm = 1'b0; disarm = 1'b0;
        chk("armdis.state", 32'(state), 0);

        // 2. Full alarm cycle
        do_arm();
        chk("arm.state", 32'(state), 1);
        chk("arm.armed", 32'(armed), 1);
        trig = 1'b1;
        step(1);                       // E0
        trig = 1'b0;
        chk("e0.state", 32'(state), 2);
        chk("e0.evt", 32'(event_cnt), 1);
        chk("e0.siren", 32'(siren), 0);
        for (int n = 1; n <= 40; n++) begin
            step(1);
            exp_siren = (n >= 8 && n < 40) ? 1 : 0;
            exp_lamp  = (n >= 8 && n < 40) ? ((((n - 8) / 4) % 2 == 0) ? 1 : 0) : 0;
            chk($sformatf("full.siren@%0d", n), 32'(siren), 32'(exp_siren));
            chk($sformatf("full.lamp@%0d", n), 32'(lamp), 32'(exp_lamp));
        end
        chk("full.end.state", 32'(state), 1);
        chk("full.end.evt", 32'(event_cnt), 1);

        // 3a. Disarm during DELAY beats trig and arm
        trig = 1'b1;
        step(1);                       // E0
        trig = 1'b0;
        chk("dis1.evt", 32'(event_cnt), 2);
        for (int n = 1; n <= 4; n++) begin
            step(1);
            chk($sformatf("dis1.siren@%0d", n), 32'(siren), 0);
        end
        disarm = 1'b1; trig = 1'b1; arm = 1'b1;
        step(1);                       // E0+5
        disarm = 1'b0; trig = 1'b0; arm = 1'b0;
        chk_all_zero("dis1");
        step(5);
        chk("dis1.later.siren", 32'(siren), 0);
        chk("dis1.later.state", 32'(state), 0);

        // 3b. Disarm during SOUND
        do_arm();
        trig = 1'b1;
        step(1);                       // E0
        trig = 1'b0;
        chk("dis2.evt", 32'(event_cnt), 3);
        step(19);                      // E0+19
        chk("dis2.pre.siren", 32'(siren), 1);
        disarm = 1'b1;
        step(1);                       // E0+20
        disarm = 1'b0;
        chk_all_zero("dis2");

        // 4. Retrigger: trig held through first expiry, dropped after reload
        do_arm();
        trig = 1'b1;
        step(1);                       // E0
        chk("rt.e0.evt", 32'(event_cnt), 4);
        for (int n = 1; n <= 72; n++) begin
            step(1);
            exp_siren = (n >= 8 && n < 72) ? 1 : 0;
            chk($sformatf("rt.siren@%0d", n), 32'(siren), 32'(exp_siren));
            if (n == 40) begin
                trig = 1'b0;
                chk("rt.reload.evt", 32'(event_cnt), 5);
                chk("rt.reload.lamp", 32'(lamp), 1);
                chk("rt.reload.state", 32'(state), 3);
            end
            if (n == 44) chk("rt.blink.lamp", 32'(lamp), 0);
        end
        chk("rt.end.state", 32'(state), 1);
        chk("rt.end.lamp", 32'(lamp), 0);

        // 5. Saturation over 17 alarm/expire cycles
        exp_evt = 5;
        for (int i = 0; i < 17; i++) begin
            trig = 1'b1;
            step(1);
            trig = 1'b0;
            exp_evt = (exp_evt == 15) ? 15 : exp_evt + 1;
            chk($sformatf("sat.evt#%0d", i), 32'(event_cnt), 32'(exp_evt));
            step(40);
            chk($sformatf("sat.state#%0d", i), 32'(state), 1);
        end
        chk("sat.final", 32'(event_cnt), 15);

        // 6. Asynchronous reset mid-SOUND, between clock edges
        trig = 1'b1;
        step(1);                       // E0
        trig = 1'b0;
        step(11);                      // E0+11
        chk("ar.pre.siren", 32'(siren), 1);
        #3 rst_n = 1'b0;               // well before the next rising edge
        #1;
        chk_all_zero("ar");
        chk("ar.evt", 32'(event_cnt), 0);
        #2 rst_n = 1'b1;
        step(3);
        chk("ar.post.state", 32'(state), 0);
        trig = 1'b1;
        step(5);
        trig = 1'b0;
        chk("ar.trig.state", 32'(state), 0);
        chk("ar.trig.evt", 32'(event_cnt), 0);
        do_arm();
        chk("ar.rearm.state", 32'(state), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
